ub_port_arbiter: RTL and testbench
==================================

# ub_port_arbiter

Parametrised arbiter for the unified-buffer read/write port. It serves NUM_REQ host/DMA requesters and one systolic input stream with backpressure. It replaces the fixed CU-steals-port mux: the systolic AGU is stalled through `sa_ready` instead of being silently overridden, and in-flight reads return tagged to the requester that issued them. It sits between the control unit, DMA engines and brain AGU on one side and port A of `unified_buffer` on the other.

## Interface
Parameters:
- NUM_REQ, 2: number of host/DMA requesters (≥1).
- ADDR_WIDTH, `ADDR_WIDTH: buffer address width.
- BUFFER_WIDTH, `BUFFER_WIDTH: buffer word width.
- RD_LATENCY, 1: memory read latency in cycles (≥1).
- STARVE_LIMIT, 8: consecutive stalled SA cycles before forced SA grant (guard builds only; ≥1).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  grant enable.
- req_valid  in  NUM_REQ  per-requester request.
- req_wr_en  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k occupies slice k.
- req_wdata  in  NUM_REQ*BUFFER_WIDTH  packed write data.
- req_ready  out  NUM_REQ  one-hot grant.
- rsp_valid  out  NUM_REQ  one-hot read-return strobe.
- rsp_data  out  BUFFER_WIDTH  read data for the requester flagged by rsp_valid, otherwise 0.
- sa_valid, sa_first, sa_last  in  1  systolic read request and stream markers.
- sa_addr  in  ADDR_WIDTH  systolic read address.
- sa_ready  out  1  systolic grant; the AGU holds its address while low.
- sa_data_valid, sa_first_out, sa_last_out  out  1  systolic return strobe and markers.
- sa_data_out  out  BUFFER_WIDTH  systolic read data, 0 when sa_data_valid is low.
- mem_wr_en, mem_first, mem_last  out  1  to the unified buffer.
- mem_addr  out  ADDR_WIDTH; mem_wdata  out  BUFFER_WIDTH  to the unified buffer.
- mem_rdata  in  BUFFER_WIDTH; mem_first_in, mem_last_in  in  1  from the unified buffer.
- sa_starved  out  1  starvation counter is at STARVE_LIMIT.

## Operation
- At most one grant per cycle. Host requesters always win over the SA, except as defined under Configuration. The SA is granted only when no host requester is valid.
- Host selection is round-robin. The search starts at pointer `rr_ptr`. After a grant to requester k, `rr_ptr` becomes (k+1) mod NUM_REQ. `rr_ptr` holds when there is no host grant.
- Granted write: `mem_wr_en` = 1 with `mem_addr` and `mem_wdata` from that requester. No response is returned.
- Granted read: a tag (valid, id, is_sa) enters a RD_LATENCY-deep shift pipeline. When the tag exits, either `rsp_valid[id]` pulses for one cycle with `rsp_data` = `mem_rdata`, or, for an SA read, `sa_data_valid` pulses with `sa_data_out` and the markers taken from `mem_first_in` and `mem_last_in`.
- `mem_first` and `mem_last` equal `sa_first` and `sa_last` only on an SA grant; otherwise they are 0. `mem_addr` and `mem_wdata` are 0 when there is no grant.
- `en` = 0: no grants are issued and the starvation counter freezes. The tag pipeline keeps advancing, so in-flight reads still return.
- A starvation counter increments each cycle that `sa_valid` is high and `sa_ready` is low, saturating at STARVE_LIMIT. It clears on an SA grant or when `sa_valid` is low.

## Timing
- Reset values: every output 0, `rr_ptr` = 0, starvation counter = 0, tag pipeline empty. A reset mid-operation drops all in-flight reads; no `rsp_valid` follows the reset.
- `req_ready`, `sa_ready` and all `mem_*` outputs are combinational from the inputs and registered state. There is no path from ready back to valid.
- Read latency is RD_LATENCY cycles from grant to return strobe. Back-to-back reads return back-to-back in grant order.
- A requester holds valid/addr/wdata until it sees ready. Dropping valid before grant is legal and simply withdraws the request.
- If the host grant and the forced SA grant would coincide, SA wins that cycle and `rr_ptr` does not advance.

## Configuration
- UB_ARB_STARVE_GUARD_EN defined: when the starvation counter equals STARVE_LIMIT and `en` = 1, the SA is granted regardless of host requests. All `req_ready` bits are 0 in that cycle. `sa_starved` is live.
- Undefined: strict host priority; the SA can starve indefinitely. The counter logic is removed and `sa_starved` is tied to 0.

## Test plan
- Reset, then idle: all outputs 0. Single read by requester 1 at address 0x10 with RD_LATENCY = 1 → `req_ready` = 2'b10 in cycle t, `rsp_valid` = 2'b10 and `rsp_data` = mem[0x10] at t+1.
- Requesters 0 and 1 continuously valid → grants alternate 01, 10, 01, 10; the SA asserting `sa_valid` meanwhile gets `sa_ready` = 0 on every cycle.
- Guard build, STARVE_LIMIT = 4, both hosts always valid, SA valid → SA granted on the 5th cycle, `sa_starved` = 1 in that cycle; the counter clears afterwards.
- SA stream of addresses 0..3 with first on 0 and last on 3, no host traffic → `sa_data_valid` pulses on 4 consecutive cycles starting one cycle later; `sa_first_out` aligns with word 0 and `sa_last_out` with word 3.
- Write 0xA5.. to address 5 by requester 0, then a read of address 5 by requester 1 the next cycle → the read returns the new data; the write produces no `rsp_valid`.
- Read granted, then `rst_n` pulsed low before return → no `rsp_valid` after reset, all outputs 0, `rr_ptr` back to 0.

Source files
------------

// File: rtl/ub_port_arbiter.sv
// rtl/ub_port_arbiter.sv - round-robin host/DMA arbiter with backpressured systolic stream for unified-buffer port A
// Optional SA starvation guard: define UB_ARB_STARVE_GUARD_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef BUFFER_WIDTH
`define BUFFER_WIDTH 32
`endif

module ub_port_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_WIDTH   = `ADDR_WIDTH,
  parameter int BUFFER_WIDTH = `BUFFER_WIDTH,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_wr_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*BUFFER_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [BUFFER_WIDTH-1:0]         rsp_data,
  input  logic                            sa_valid,
  input  logic                            sa_first,
  input  logic                            sa_last,
  input  logic [ADDR_WIDTH-1:0]           sa_addr,
  output logic                            sa_ready,
  output logic                            sa_data_valid,
  output logic                            sa_first_out,
  output logic                            sa_last_out,
  output logic [BUFFER_WIDTH-1:0]         sa_data_out,
  output logic                            mem_wr_en,
  output logic                            mem_first,
  output logic                            mem_last,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [BUFFER_WIDTH-1:0]         mem_wdata,
  input  logic [BUFFER_WIDTH-1:0]         mem_rdata,
  input  logic                            mem_first_in,
  input  logic                            mem_last_in,
  output logic                            sa_starved
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 1 || RD_LATENCY < 1 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("ub_port_arbiter: illegal parameter value");
  end

  logic [PW-1:0]                 r_rr_ptr;
  logic [RD_LATENCY-1:0]         r_tag_valid;
  logic [RD_LATENCY-1:0]         r_tag_sa;
  logic [RD_LATENCY-1:0][PW-1:0] r_tag_id;

  logic          w_hi_found;
  logic          w_any_found;
  logic [PW-1:0] w_hi_idx;
  logic [PW-1:0] w_any_idx;
  logic [PW-1:0] w_host_idx;
  logic [PW-1:0] w_rr_next;
  logic          w_force;
  logic          w_host_grant;
  logic          w_sa_grant;
  logic          w_host_wr;
  logic          w_rd_grant;
  logic          w_out_valid;
  logic          w_out_sa;
  logic [PW-1:0] w_out_id;

  // Prefer the lowest valid index at or above rr_ptr, else wrap to the lowest valid index.
  always_comb begin
    w_hi_found  = 1'b0;
    w_any_found = 1'b0;
    w_hi_idx    = '0;
    w_any_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        w_any_found = 1'b1;
        w_any_idx   = PW'(k);
        if (k >= int'(r_rr_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = PW'(k);
        end
      end
    end
  end

  assign w_host_idx = w_hi_found ? w_hi_idx : w_any_idx;
  assign w_rr_next  = (w_host_idx == PW'(NUM_REQ - 1)) ? '0 : w_host_idx + PW'(1);

`ifdef UB_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] r_starve_cnt;

  assign sa_starved = (r_starve_cnt == CW'(STARVE_LIMIT));
  assign w_force    = en && sa_valid && sa_starved;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (en) begin
      if (!sa_valid || w_sa_grant) begin
        r_starve_cnt <= '0;
      end else if (!sa_starved) begin
        r_starve_cnt <= r_starve_cnt + CW'(1);
      end
    end
  end
`else
  assign sa_starved = 1'b0;
  assign w_force    = 1'b0;
`endif

  assign w_host_grant = en && w_any_found && !w_force;
  assign w_sa_grant   = en && sa_valid && (w_force || !w_any_found);
  assign sa_ready     = w_sa_grant;

  always_comb begin
    req_ready = '0;
    w_host_wr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_first = 1'b0;
    mem_last  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_host_grant && (w_host_idx == PW'(k))) begin
        req_ready[k] = 1'b1;
        w_host_wr    = req_wr_en[k];
        mem_addr     = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata    = req_wdata[k*BUFFER_WIDTH +: BUFFER_WIDTH];
      end
    end
    if (w_sa_grant) begin
      mem_addr  = sa_addr;
      mem_first = sa_first;
      mem_last  = sa_last;
    end
  end

  assign mem_wr_en  = w_host_grant && w_host_wr;
  assign w_rd_grant = (w_host_grant && !w_host_wr) || w_sa_grant;

  // Read tags ride alongside the memory pipeline so each return knows its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_tag_valid <= '0;
      r_tag_sa    <= '0;
      r_tag_id    <= '0;
    end else begin
      r_tag_valid[0] <= w_rd_grant;
      r_tag_sa[0]    <= w_sa_grant;
      r_tag_id[0]    <= w_host_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
        r_tag_sa[i]    <= r_tag_sa[i-1];
        r_tag_id[i]    <= r_tag_id[i-1];
      end
      if (w_host_grant) begin
        r_rr_ptr <= w_rr_next;
      end
    end
  end

  assign w_out_valid = r_tag_valid[RD_LATENCY-1];
  assign w_out_sa    = r_tag_sa[RD_LATENCY-1];
  assign w_out_id    = r_tag_id[RD_LATENCY-1];

  always_comb begin
    rsp_valid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rsp_valid[k] = w_out_valid && !w_out_sa && (w_out_id == PW'(k));
    end
  end

  assign rsp_data      = (w_out_valid && !w_out_sa) ? mem_rdata : '0;
  assign sa_data_valid = w_out_valid && w_out_sa;
  assign sa_data_out   = sa_data_valid ? mem_rdata : '0;
  assign sa_first_out  = sa_data_valid && mem_first_in;
  assign sa_last_out   = sa_data_valid && mem_last_in;

endmodule

// File: tb/tb_ub_port_arbiter.sv
// tb/tb_ub_port_arbiter.sv - directed self-checking bench for ub_port_arbiter
module tb_ub_port_arbiter;
  localparam int NR = 2;
  localparam int AW = 8;
  localparam int BW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, en;
  logic [NR-1:0]   req_valid, req_wr_en, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*BW-1:0] req_wdata;
  logic [BW-1:0]   rsp_data, sa_data_out, mem_wdata, mem_rdata;
  logic            sa_valid, sa_first, sa_last, sa_ready;
  logic [AW-1:0]   sa_addr, mem_addr;
  logic            sa_data_valid, sa_first_out, sa_last_out;
  logic            mem_wr_en, mem_first, mem_last, mem_first_in, mem_last_in, sa_starved;

  ub_port_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .BUFFER_WIDTH(BW), .RD_LATENCY(1), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_wr_en(req_wr_en), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .sa_valid(sa_valid), .sa_first(sa_first), .sa_last(sa_last), .sa_addr(sa_addr),
    .sa_ready(sa_ready), .sa_data_valid(sa_data_valid), .sa_first_out(sa_first_out),
    .sa_last_out(sa_last_out), .sa_data_out(sa_data_out),
    .mem_wr_en(mem_wr_en), .mem_first(mem_first), .mem_last(mem_last),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_first_in(mem_first_in), .mem_last_in(mem_last_in),
    .sa_starved(sa_starved)
  );

  // One-cycle buffer: word at address a reads 0x1000+a unless it was written.
  logic [AW-1:0] m_raddr, m_waddr;
  logic [BW-1:0] m_wdat;
  logic          m_wvld, m_first, m_last;
  always @(posedge clk) begin
    m_raddr <= mem_addr;
    m_first <= mem_first;
    m_last  <= mem_last;
    if (!rst_n) m_wvld <= 1'b0;
    else if (mem_wr_en) begin
      m_wvld  <= 1'b1;
      m_waddr <= mem_addr;
      m_wdat  <= mem_wdata;
    end
  end
  assign mem_rdata    = (m_wvld && m_waddr == m_raddr) ? m_wdat : (16'h1000 + {8'h00, m_raddr});
  assign mem_first_in = m_first;
  assign mem_last_in  = m_last;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    req_valid = '0; req_wr_en = '0; req_addr = '0; req_wdata = '0;
    sa_valid = 1'b0; sa_first = 1'b0; sa_last = 1'b0; sa_addr = '0;
  endtask

  logic [1:0] alt_g [6];
  logic       alt_sa[6];
  logic       alt_st[6];

  initial begin
`ifdef UB_ARB_STARVE_GUARD_EN
    alt_g  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01};
    alt_sa = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    alt_st = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    alt_g  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    alt_sa = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    alt_st = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    rst_n = 1'b0; en = 1'b0; idle();
    repeat (2) @(posedge clk);
    #3;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_sa_ready", sa_ready, 0);
    check("rst_sa_dvalid", sa_data_valid, 0);
    check("rst_mem_wr_en", mem_wr_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_sa_starved", sa_starved, 0);
    rst_n = 1'b1; en = 1'b1;

    tick(); req_valid = 2'b10; req_addr = {8'h10, 8'h00}; settle();
    check("rd1_ready", req_ready, 2'b10);
    check("rd1_mem_addr", mem_addr, 8'h10);
    tick(); idle(); settle();
    check("rd1_rsp_valid", rsp_valid, 2'b10);
    check("rd1_rsp_data", rsp_data, 16'h1010);

    tick(); req_valid = 2'b11; req_addr = {8'h21, 8'h20}; sa_valid = 1'b1; sa_addr = 8'h30;
    for (int i = 0; i < 6; i++) begin
      settle();
      check($sformatf("alt_ready_%0d", i), req_ready, alt_g[i]);
      check($sformatf("alt_sa_ready_%0d", i), sa_ready, alt_sa[i]);
      check($sformatf("alt_starved_%0d", i), sa_starved, alt_st[i]);
      if (i > 0) begin
        check($sformatf("alt_rsp_%0d", i), rsp_valid, alt_g[i-1]);
        check($sformatf("alt_rdata_%0d", i), rsp_data,
              alt_g[i-1] == 2'b01 ? 16'h1020 : alt_g[i-1] == 2'b10 ? 16'h1021 : 16'h0000);
        check($sformatf("alt_sa_dv_%0d", i), sa_data_valid, alt_sa[i-1]);
        check($sformatf("alt_sa_data_%0d", i), sa_data_out, alt_sa[i-1] ? 16'h1030 : 16'h0000);
      end
      tick();
    end
    idle(); settle();
    check("alt_last_rsp", rsp_valid, alt_g[5]);
    check("alt_last_rdata", rsp_data, alt_g[5] == 2'b01 ? 16'h1020 : 16'h1021);

    tick(); sa_valid = 1'b1; sa_addr = 8'h00; sa_first = 1'b1; settle();
    check("sa_ready_w0", sa_ready, 1);
    check("sa_mem_first", mem_first, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) begin
        sa_valid = 1'b1; sa_addr = AW'(i + 1); sa_first = 1'b0; sa_last = (i == 2);
      end else begin
        idle();
      end
      settle();
      check($sformatf("sa_dv_%0d", i), sa_data_valid, 1);
      check($sformatf("sa_data_%0d", i), sa_data_out, 16'h1000 + i);
      check($sformatf("sa_first_%0d", i), sa_first_out, i == 0);
      check($sformatf("sa_last_%0d", i), sa_last_out, i == 3);
    end
    tick(); settle();
    check("sa_dv_end", sa_data_valid, 0);
    check("sa_data_end", sa_data_out, 0);

    tick(); req_valid = 2'b01; req_wr_en = 2'b01; req_addr = {8'h00, 8'h05};
    req_wdata = {16'h0000, 16'hA5A5}; settle();
    check("wr_ready", req_ready, 2'b01);
    check("wr_mem_wr_en", mem_wr_en, 1);
    check("wr_mem_wdata", mem_wdata, 16'hA5A5);
    check("wr_mem_addr", mem_addr, 8'h05);
    tick(); req_valid = 2'b10; req_wr_en = 2'b00; req_addr = {8'h05, 8'h00}; req_wdata = '0; settle();
    check("raw_ready", req_ready, 2'b10);
    check("wr_no_rsp", rsp_valid, 0);
    tick(); idle(); settle();
    check("raw_rsp_valid", rsp_valid, 2'b10);
    check("raw_rsp_data", rsp_data, 16'hA5A5);

    tick(); req_valid = 2'b01; req_addr = {8'h00, 8'h10}; settle();
    check("pre_rst_ready", req_ready, 2'b01);
    tick(); settle();
    check("pre_rst_rsp", rsp_valid, 2'b01);
    check("pre_rst_ready2", req_ready, 2'b01);
    #1 rst_n = 1'b0;
    tick(); idle(); settle();
    check("in_rst_rsp_valid", rsp_valid, 0);
    check("in_rst_rsp_data", rsp_data, 0);
    check("in_rst_ready", req_ready, 0);
    check("in_rst_mem_addr", mem_addr, 0);
    check("in_rst_sa_dv", sa_data_valid, 0);
    rst_n = 1'b1;
    tick(); settle();
    check("post_rst_rsp", rsp_valid, 0);
    req_valid = 2'b11; settle();
    check("rr_after_rst", req_ready, 2'b01);
    en = 1'b0; settle();
    check("en_off_ready", req_ready, 0);
    check("en_off_wr", mem_wr_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
